// File: rtl/openflow_axil_master.sv
// openflow_axil_master: single-outstanding command/response port to AXI4-Lite
// master. Every output is a register loaded from the next-state logic.
// Optional watchdog: define AXIL_MASTER_TIMEOUT_EN to abort hung transactions
// after C_TIMEOUT_CYCLES busy cycles (SLVERR + rsp_timeout).
module openflow_axil_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_TIMEOUT_CYCLES   = 1024
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_wr,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr,
  output logic                            awvalid,
  input  logic                            awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb,
  output logic                            wvalid,
  input  logic                            wready,
  input  logic [1:0]                      bresp,
  input  logic                            bvalid,
  output logic                            bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr,
  output logic                            arvalid,
  input  logic                            arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]                      rresp,
  input  logic                            rvalid,
  output logic                            rready
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int SW = C_M_AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

  state_t          state_q, state_d;
  logic            aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic            to_q, to_d;
  logic            cmd_ready_d, awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d, rsp_valid_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_d, rsp_rdata_d;
  logic [SW-1:0]   wstrb_d;
  logic [1:0]      rsp_resp_d;
  logic            busy, expire;

  assign busy        = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                       (state_q == RD_REQ) || (state_q == RD_RESP);
  assign awaddr      = addr_q;
  assign araddr      = addr_q;
  assign rsp_timeout = to_q;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CW = (C_TIMEOUT_CYCLES > 2) ? $clog2(C_TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(C_TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q;

  // Busy-cycle counter, cleared while idle so every command starts from zero
  always_ff @(posedge aclk) begin
    if (areset)              cnt_q <= '0;
    else if (state_q == IDLE) cnt_q <= '0;
    else if (busy)           cnt_q <= cnt_q + 1'b1;
  end

  assign expire = busy && (cnt_q == LIMIT);
`else
  logic unused_cfg;
  assign unused_cfg = ^C_TIMEOUT_CYCLES;
  assign expire     = 1'b0;
`endif

  // Next-state and next-output logic; registers hold unless a handshake moves them
  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    to_d        = to_q;
    cmd_ready_d = 1'b0;
    awvalid_d   = awvalid;
    wvalid_d    = wvalid;
    bready_d    = bready;
    arvalid_d   = arvalid;
    rready_d    = rready;
    rsp_valid_d = rsp_valid;
    addr_d      = addr_q;
    wdata_d     = wdata;
    wstrb_d     = wstrb;
    rsp_rdata_d = rsp_rdata;
    rsp_resp_d  = rsp_resp;
    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          to_d        = 1'b0;
          if (cmd_wr) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        if (awvalid && awready) begin aw_done_d = 1'b1; awvalid_d = 1'b0; end
        if (wvalid && wready)   begin w_done_d  = 1'b1; wvalid_d  = 1'b0; end
        if (aw_done_d && w_done_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          state_d     = RSP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = bresp;
          rsp_rdata_d = '0;
        end
      end
      RD_REQ: begin
        if (arready) begin
          state_d   = RD_RESP;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RD_RESP: begin
        if (rvalid) begin
          state_d     = RSP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = rresp;
          rsp_rdata_d = rdata;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Watchdog abort only if no completing handshake landed this cycle
    if (expire && (state_d == state_q)) begin
      state_d     = RSP;
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      arvalid_d   = 1'b0;
      bready_d    = 1'b0;
      rready_d    = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_resp_d  = 2'b10;
      rsp_rdata_d = '0;
      to_d        = 1'b1;
    end
  end

  // State and output registers; reset clears everything, dropping any transaction
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      to_q      <= 1'b0;
      cmd_ready <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      rsp_valid <= 1'b0;
      addr_q    <= '0;
      wdata     <= '0;
      wstrb     <= '0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      to_q      <= to_d;
      cmd_ready <= cmd_ready_d;
      awvalid   <= awvalid_d;
      wvalid    <= wvalid_d;
      bready    <= bready_d;
      arvalid   <= arvalid_d;
      rready    <= rready_d;
      rsp_valid <= rsp_valid_d;
      addr_q    <= addr_d;
      wdata     <= wdata_d;
      wstrb     <= wstrb_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_resp  <= rsp_resp_d;
    end
  end
endmodule
